uart_tx_engine: RTL and testbench

//  UART serial transmitter that drains the transmit FIFO (tfifo) and shifts each

---
 rtl/uart_tx_engine.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter: reads one word at a time from the transmit FIFO and shifts it out
// as a start bit, WIDTH data bits LSB-first, an optional parity bit and 1 or 2 stop bits.
module uart_tx_engine #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tx_en_i,
    input  logic             fifo_empty_i,
    input  logic             d_ready_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             re_o,
    output logic             tr_bz_o,
    output logic             tx_o,
    output logic             tx_done_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(WIDTH - 1);
    localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle, StReq, StWait, StStart, StData, StParity, StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              re_q, re_d;
    logic              bz_q, bz_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              more_work;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        done_d    = 1'b0;
        bit_end   = (baud_q == BaudLast);
        more_work = tx_en_i && !fifo_empty_i;

        unique case (state_q)
            StIdle: begin
                if (more_work) state_d = StReq;
            end
            StReq: state_d = StWait;
            StWait: begin
                // No d_ready means the FIFO served a write instead; retry from IDLE.
                if (d_ready_i) begin
                    shift_d = fifo_data_i;
                    par_d   = (^fifo_data_i) ^ (PARITY_ODD != 0);
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end else begin
                    state_d = StIdle;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StParity: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = more_work ? StReq : StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        re_d = (state_d == StReq);
        bz_d = (state_d == StStart) || (state_d == StData) ||
               (state_d == StParity) || (state_d == StStop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            re_q    <= 1'b0;
            bz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            re_q    <= re_d;
            bz_q    <= bz_d;
            done_q  <= done_d;
        end
    end

    assign tx_o      = tx_q;
    assign re_o      = re_q;
    assign tr_bz_o   = bz_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: FIFO model feeds words, a line monitor decodes frames and
// compares them against a queue of expected words.
module tb_uart_tx_engine;

    localparam int W    = 8;
    localparam int C    = 4;
    localparam int PEN  = 1;
    localparam int PODD = 1;
    localparam int SB   = 2;
    localparam int L    = 1 + W + PEN + SB;
    localparam int FL   = L * C;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         tx_en_i;
    logic         fifo_empty_i;
    logic         d_ready_i;
    logic [W-1:0] fifo_data_i;
    logic         re_o;
    logic         tr_bz_o;
    logic         tx_o;
    logic         tx_done_o;

    uart_tx_engine #(
        .WIDTH        (W),
        .CLKS_PER_BIT (C),
        .PARITY_EN    (PEN),
        .PARITY_ODD   (PODD),
        .STOP_BITS    (SB)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .tx_en_i      (tx_en_i),
        .fifo_empty_i (fifo_empty_i),
        .d_ready_i    (d_ready_i),
        .fifo_data_i  (fifo_data_i),
        .re_o         (re_o),
        .tr_bz_o      (tr_bz_o),
        .tx_o         (tx_o),
        .tx_done_o    (tx_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int starts[$];
    int re_cnt = 0, done_cnt = 0, frames_ok = 0, bz_cycles = 0;
    int spurious = 0, dbl_re = 0, n_push = 0;
    int empty_fall_cyc = 0;
    int deny_cnt = 0;
    bit rand_deny = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        n_push++;
    endtask

    // FIFO model: answers a read request with d_ready during the following cycle.
    initial begin : fifo_model
        logic rd, prev_re;
        fifo_empty_i = 1'b1;
        d_ready_i    = 1'b0;
        fifo_data_i  = '0;
        prev_re      = 1'b0;
        forever begin
            @(negedge clk_i);
            rd = re_o && rst_n_i;
            if (rd && prev_re) dbl_re++;
            prev_re = rd;
            @(posedge clk_i);
            #1;
            d_ready_i = 1'b0;
            if (rd && rst_n_i) begin
                re_cnt++;
                if (deny_cnt > 0) begin
                    deny_cnt--;
                end else if (rand_deny && $urandom_range(0, 3) == 0) begin
                    // write-priority cycle: no data this time
                end else if (fifo_q.size() > 0) begin
                    fifo_data_i = fifo_q.pop_front();
                    d_ready_i   = 1'b1;
                end else begin
                    spurious++;
                end
            end
            if (fifo_empty_i && fifo_q.size() > 0) empty_fall_cyc = cyc;
            fifo_empty_i = (fifo_q.size() == 0);
        end
    end

    // Line monitor: captures one frame of samples after a falling edge and decodes it.
    initial begin : monitor
        logic samp [FL];
        logic [L-1:0] bits;
        logic [W-1:0] e;
        bit in_frame, bz_ok, hold_bad;
        int idx;
        in_frame = 1'b0;
        idx = 0;
        forever begin
            @(negedge clk_i);
            if (tr_bz_o) bz_cycles++;
            if (tx_done_o) done_cnt++;
            if (!rst_n_i) begin
                in_frame = 1'b0;
            end else if (in_frame) begin
                if (idx < FL) begin
                    samp[idx] = tx_o;
                    bz_ok = bz_ok && tr_bz_o;
                    idx++;
                end else begin
                    in_frame = 1'b0;
                    hold_bad = 1'b0;
                    for (int b = 0; b < L; b++) begin
                        bits[b] = samp[b*C];
                        for (int k = 1; k < C; k++)
                            if (samp[b*C+k] !== bits[b]) hold_bad = 1'b1;
                    end
                    chk("bit_hold_stable", int'(hold_bad), 0);
                    chk("busy_through_frame", int'(bz_ok), 1);
                    chk("done_after_stop", int'(tx_done_o), 1);
                    chk("idle_after_frame", int'(tr_bz_o), 0);
                    chk("stop_bits", int'(bits[L-1 -: SB]), (1 << SB) - 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_word", int'(bits[W:1]), int'(e));
                        chk("parity_bit", int'(bits[W+1]), int'((^e) ^ (PODD != 0)));
                        frames_ok++;
                    end
                end
            end else if (tx_o == 1'b0) begin
                in_frame = 1'b1;
                samp[0]  = tx_o;
                bz_ok    = tr_bz_o;
                idx      = 1;
                starts.push_back(cyc);
            end
        end
    end

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 20000) begin
            @(negedge clk_i);
            n++;
        end
        chk({nm, "_drain_timeout"}, int'(n >= 20000), 0);
        repeat (6) @(negedge clk_i);
    endtask

    task automatic wait_start(input int n0);
        int n;
        n = 0;
        while (starts.size() == n0 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        chk("frame_start_timeout", int'(n >= 5000), 0);
    endtask

    initial begin : stimulus
        int s0, r0, d0, f0, bad;
        rst_n_i = 1'b0;
        tx_en_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("reset_tx", int'(tx_o), 1);
        chk("reset_re", int'(re_o), 0);
        chk("reset_bz", int'(tr_bz_o), 0);
        chk("reset_done", int'(tx_done_o), 0);
        rst_n_i = 1'b1;

        // Empty FIFO: line stays quiet
        bad = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (re_o !== 1'b0 || tx_o !== 1'b1 || tr_bz_o !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("idle_no_reads", re_cnt, 0);

        // Single word, latency and busy length
        bz_cycles = 0;
        s0 = starts.size();
        push(8'hA5);
        wait_drain("single");
        chk("single_latency", starts[s0] - empty_fall_cyc, 3);
        chk("single_reads", re_cnt, 1);
        chk("single_done", done_cnt, 1);
        chk("single_busy_cycles", bz_cycles, FL);

        // Parity case: 0x07 with odd parity gives parity bit 0
        push(8'h07);
        wait_drain("parity");

        // Back-to-back frames
        r0 = re_cnt; d0 = done_cnt; s0 = starts.size();
        push(8'h00); push(8'hFF); push(8'h3C);
        wait_drain("burst");
        chk("burst_reads", re_cnt - r0, 3);
        chk("burst_done", done_cnt - d0, 3);
        chk("burst_gap0", starts[s0+1] - starts[s0], FL + 2);
        chk("burst_gap1", starts[s0+2] - starts[s0+1], FL + 2);
        chk("burst_fifo_empty", int'(fifo_empty_i), 1);

        // Read denied once in WAIT: retry, single frame
        r0 = re_cnt; f0 = frames_ok; s0 = starts.size();
        deny_cnt = 1;
        push(8'h5A);
        wait_drain("retry");
        chk("retry_reads", re_cnt - r0, 2);
        chk("retry_frames", frames_ok - f0, 1);
        chk("retry_latency", starts[s0] - empty_fall_cyc, 6);

        // tx_en dropped mid-frame: current frame finishes, next one waits
        f0 = frames_ok; s0 = starts.size();
        push(8'h96); push(8'h69);
        wait_start(s0);
        tx_en_i = 1'b0;
        repeat (3 * FL) @(negedge clk_i);
        chk("txen_off_frames", frames_ok - f0, 1);
        chk("txen_off_pending", fifo_q.size(), 1);
        tx_en_i = 1'b1;
        wait_drain("txen_on");
        chk("txen_on_frames", frames_ok - f0, 2);

        // Asynchronous reset in the middle of DATA
        s0 = starts.size();
        push(8'h81);
        wait_start(s0);
        repeat (12) @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("midreset_tx", int'(tx_o), 1);
        chk("midreset_bz", int'(tr_bz_o), 0);
        chk("midreset_re", int'(re_o), 0);
        exp_q.delete();
        n_push--;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        f0 = frames_ok;
        push(8'hC3);
        wait_drain("after_reset");
        chk("after_reset_frames", frames_ok - f0, 1);

        // Random words, random spacing and random write-priority denials
        rand_deny = 1'b1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk_i);
            push(W'($urandom_range(0, 255)));
        end
        wait_drain("random");
        rand_deny = 1'b0;

        chk("total_frames", frames_ok, n_push);
        chk("no_spurious_reads", spurious, 0);
        chk("no_double_reads", dbl_re, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
